// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard controller for the 5-stage RV32I pipeline.
// It tracks the producers that are in flight in EX and MEM. From them it
// generates the load-use stall, the taken-branch/jump flush and the
// registered ALU operand forwarding selects. It also counts stall and flush
// cycles in saturating counters.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   id_valid, id_opcode(inst[6:2]),
//   id_rs1, id_rs2, id_rd             instruction currently in ID
//   ex_redirect                       EX instruction redirects the PC
//   stall, flush_ifid, flush_idex     combinational pipeline controls
//   fwd_sel1, fwd_sel2                EX operand source: 00 rf, 01 EX/MEM, 10 MEM/WB
//   stall_cnt, flush_cnt              saturating event counters (CNT_W bits)
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             ex_redirect,
  output logic             stall,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [1:0]       fwd_sel1,
  output logic [1:0]       fwd_sel2,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_IMME   = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_R_TYPE = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wr;   // writes a non-x0 destination
    logic       ld;
  } slot_t;

  // The WB slot is not kept. Nothing reads it, because WB producers reach
  // the EX stage through the regfile's write-before-read path.
  slot_t ex_q, mem_q, id_slot;

  logic uses_rs1, uses_rs2, writes_rd, is_load;
  logic hit1_ex, hit2_ex, hit1_mem, hit2_mem;
  logic load_use, id_kill;
  logic [1:0] sel1_d, sel2_d, sel1_q, sel2_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  function automatic logic src_hit(logic used, logic [4:0] src, slot_t s);
    return used && (src != 5'd0) && s.valid && s.wr && (s.rd == src);
  endfunction

  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    is_load   = 1'b0;
    unique case (id_opcode)
      OP_R_TYPE: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1; end
      OP_IMME:   begin uses_rs1 = 1'b1; writes_rd = 1'b1; end
      OP_LOAD:   begin uses_rs1 = 1'b1; writes_rd = 1'b1; is_load = 1'b1; end
      OP_STORE:  begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OP_BRANCH: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OP_JALR:   begin uses_rs1 = 1'b1; writes_rd = 1'b1; end
      OP_JAL, OP_LUI, OP_AUIPC: writes_rd = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    hit1_ex  = src_hit(uses_rs1, id_rs1, ex_q);
    hit2_ex  = src_hit(uses_rs2, id_rs2, ex_q);
    hit1_mem = src_hit(uses_rs1, id_rs1, mem_q);
    hit2_mem = src_hit(uses_rs2, id_rs2, mem_q);

    // A redirect kills the ID instruction, so the redirect wins over a stall.
    load_use   = id_valid && ex_q.ld && (hit1_ex || hit2_ex);
    stall      = rst_n && load_use && !ex_redirect;
    flush_ifid = rst_n && ex_redirect;
    flush_idex = rst_n && ex_redirect;

    id_kill = !id_valid || stall || ex_redirect;

    id_slot.valid = !id_kill;
    id_slot.rd    = id_rd;
    id_slot.wr    = writes_rd && (id_rd != 5'd0);
    id_slot.ld    = is_load;

    // The youngest producer (EX) takes priority. A load in EX never reaches
    // this point, because it forces a stall and so a bubble.
    sel1_d = 2'b00;
    sel2_d = 2'b00;
    if (!id_kill) begin
      if (hit1_ex)       sel1_d = 2'b01;
      else if (hit1_mem) sel1_d = 2'b10;
      if (hit2_ex)       sel2_d = 2'b01;
      else if (hit2_mem) sel2_d = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      sel1_q      <= 2'b00;
      sel2_q      <= 2'b00;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      mem_q  <= ex_q;
      ex_q   <= id_slot;
      sel1_q <= sel1_d;
      sel2_q <= sel2_d;
      if (stall && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_idex && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign fwd_sel1  = sel1_q;
  assign fwd_sel2  = sel2_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
